osd_cmd_tx: RTL and testbench
=============================

Name: osd_cmd_tx

Overview:
MPU-side transmitter for the OSD command bus (io_osd / io_strobe / io_din) consumed by the OSD overlay in the video path. Accepts one high-level request at a time: enable (with optional info-window parameters), disable, or buffer write. Serialises each request into the framed strobe protocol: command word, then parameter or data words, then io_osd low. Lives in clk_sys next to the MPU register block; the byte source for writes is a valid/ready stream.

Parameters:
STB_HIGH, 1, cycles io_strobe is held high per word (>=1)
STB_LOW, 1, cycles io_strobe is held low after each high phase (>=1)
OSD_GAP, 2, cycles io_osd is held low after a frame before the next request is accepted (>=1)

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid&req_ready
req_op  in  2  0=DISABLE, 1=ENABLE, 2=WRITE, 3=reserved (accepted, treated as DISABLE)
req_info  in  1  ENABLE: info-window mode (cmd bit2)
req_nostat  in  1  ENABLE: suppress osd_status (cmd bit3)
req_block  in  5  WRITE: block index, placed in cmd bits[4:0]
req_len  in  9  WRITE: data byte count, 0..256
prm_infox, prm_infoy  in  12 each  info-window x/y
prm_infow, prm_infoh  in  6 each  info-window width/height in 8-pixel units
prm_osd_color  in  9  background tint
prm_whole_color  in  16  foreground colour, RGB555
wr_data  in  8  write byte
wr_valid  in  1  write byte available
wr_ready  out  1  1-cycle pulse when wr_data is consumed
io_osd  out  1  frame enable
io_strobe  out  1  word strobe
io_din  out  16  word data
busy  out  1  high from acceptance until end of gap
done  out  1  1-cycle pulse on the first cycle io_osd returns low

Behaviour:
- Reset: io_osd=0, io_strobe=0, io_din=0, wr_ready=0, done=0, busy=0. req_ready=1 on the cycle after reset deasserts.
- All request fields are latched on acceptance. req_ready=~busy.
- FSM states: IDLE -> SETUP -> CMD -> {PARAM | DATA | DATA_WAIT} -> GAP -> IDLE.
- Acceptance at cycle T:
  - SETUP at T+1: io_osd=1, io_strobe=0.
  - CMD at T+2: io_din={8'h00,cmd}, strobe high for STB_HIGH cycles, then low for STB_LOW cycles.
- Word slot: io_din changes only on the cycle its strobe rises. It is held for the full slot of STB_HIGH+STB_LOW cycles.
- Command byte encoding:
  - DISABLE = 8'h40.
  - ENABLE = 8'h41 | req_info<<2 | req_nostat<<3.
  - WRITE = 8'h20 | req_block.
- PARAM (ENABLE with req_info=1): six words in order.
  - {4'h0,infox}
  - {4'h0,infoy}
  - {10'h0,infow}
  - {10'h0,infoh}
  - {7'h0,osd_color}
  - whole_color
- ENABLE with req_info=0 and DISABLE: command word only.
- DATA (WRITE): req_len words {8'h00,wr_data}.
  - Entering a slot requires wr_valid=1. wr_ready pulses on the same cycle the strobe rises, and the byte is registered into io_din that cycle.
  - If wr_valid=0 when a slot is due, enter DATA_WAIT: io_osd stays 1, io_strobe stays 0, wait indefinitely.
  - req_len=0: command word only. Values >256 are clamped to 256.
- GAP: after the last word's low phase, io_osd=0 for OSD_GAP cycles. done pulses on the first gap cycle; busy drops after the last gap cycle.
- Total cycles, acceptance to done: 1 + (1+N)*(STB_HIGH+STB_LOW) + 1, with N = words after the command and no stalls.
- Reset mid-frame: outputs are forced low next cycle and the request is dropped. The receiver will then act on the partially sent command byte; higher software must resend.

Optional Feature:
OSD_TX_PARAM_EN
- Defined: PARAM state and prm_* ports are present; behaviour as above.
- Undefined: prm_* ports are ignored and the PARAM state is removed. ENABLE always sends the command word only, even when req_info=1; the receiver keeps its previous info geometry and colours.

Decomposition:
- Shared package osd_cmd_pkg:
  - op enum (OP_DISABLE, OP_ENABLE, OP_WRITE).
  - Command constants CMD_ENABLE_BASE=8'h40, CMD_WRITE_BASE=8'h20.
  - Bit positions INFO_BIT=2, NOSTAT_BIT=3.
  - PARAM_WORDS=6, BLOCK_BYTES=256.
- Sub-module osd_strobe_slot: times one word (STB_HIGH/STB_LOW counters, start/finished handshake, io_din hold). The main FSM sequences words through it.

Test Plan:
- DISABLE, STB_HIGH=STB_LOW=1 -> io_osd 1 at T+1; one strobe at T+2 with io_din=16'h0040; io_osd 0 at T+4; done at T+4.
- ENABLE with info=1, x=12'h010, y=12'h020, w=6'd8, h=6'd4, color=9'h1FF, whole=16'h7FFF -> strobes carry 0045,0010,0020,0008,0004,01FF,7FFF; done at T+16.
- WRITE block=5, len=3, bytes AA,BB,CC always valid -> strobes carry 0025,00AA,00BB,00CC; wr_ready pulses coincide with strobe rises 2,3,4.
- WRITE len=2 with wr_valid low for 10 cycles before byte 2 -> io_osd stays 1, strobe stays low through the stall; the byte is sent on the cycle wr_valid rises; no extra wr_ready pulses.
- Reset asserted during the 3rd data word -> next cycle io_osd=0, io_strobe=0, busy=0, no done pulse; a new DISABLE request is accepted after reset.
- OSD_TX_PARAM_EN undefined, ENABLE with info=1 -> single strobe carrying 16'h0045; done at T+4.

Source files
------------

// File: rtl/osd_cmd_pkg.sv
// osd_cmd_pkg: shared types and constants for the OSD command bus transmitter.
//   op_e        - high-level request opcode
//   tx_state_e  - transmitter FSM states (PARAM exists only with OSD_TX_PARAM_EN)
//   decode_op   - maps the raw 2-bit request opcode, reserved code 3 -> DISABLE
//   encode_cmd  - builds the command byte for a request
//   clamp_len   - limits a write length to one buffer block
// Optional feature macro: OSD_TX_PARAM_EN (info-window parameter words).
package osd_cmd_pkg;

    typedef enum logic [1:0] {
        OP_DISABLE = 2'd0,
        OP_ENABLE  = 2'd1,
        OP_WRITE   = 2'd2
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_CMD       = 3'd2,
`ifdef OSD_TX_PARAM_EN
        ST_PARAM     = 3'd3,
`endif
        ST_DATA      = 3'd4,
        ST_DATA_WAIT = 3'd5,
        ST_GAP       = 3'd6
    } tx_state_e;

    localparam logic [7:0] CMD_ENABLE_BASE = 8'h40;
    localparam logic [7:0] CMD_WRITE_BASE  = 8'h20;
    localparam int         INFO_BIT        = 2;
    localparam int         NOSTAT_BIT      = 3;
    localparam int         PARAM_WORDS     = 6;
    localparam int         BLOCK_BYTES     = 256;

    function automatic op_e decode_op(input logic [1:0] raw);
        op_e op;
        case (raw)
            2'd1:    op = OP_ENABLE;
            2'd2:    op = OP_WRITE;
            default: op = OP_DISABLE;
        endcase
        return op;
    endfunction

    function automatic logic [7:0] encode_cmd(input op_e        op,
                                              input logic       info,
                                              input logic       nostat,
                                              input logic [4:0] block);
        logic [7:0] cmd;
        case (op)
            OP_ENABLE: begin
                cmd             = CMD_ENABLE_BASE | 8'h01;
                cmd[INFO_BIT]   = info;
                cmd[NOSTAT_BIT] = nostat;
            end
            OP_WRITE: cmd = CMD_WRITE_BASE | {3'b000, block};
            default:  cmd = CMD_ENABLE_BASE;
        endcase
        return cmd;
    endfunction

    function automatic logic [8:0] clamp_len(input logic [8:0] len);
        return (len > 9'(BLOCK_BYTES)) ? 9'(BLOCK_BYTES) : len;
    endfunction

endpackage

// File: rtl/osd_cmd_tx_slot.sv
// osd_strobe_slot: times one word on the OSD strobe bus.
//   clk_sys, reset  - system clock, synchronous active-high reset
//   start           - begin a slot this edge with 'word'
//   word            - word to present on io_din for the slot
//   io_strobe       - high STB_HIGH cycles, then low STB_LOW cycles
//   io_din          - loaded only on the edge the strobe rises, held otherwise
//   active          - a slot is in progress
//   finished        - last cycle of the low phase; a new start may be issued now
//                     so consecutive words run back to back
module osd_strobe_slot #(
    parameter int STB_HIGH = 1,
    parameter int STB_LOW  = 1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] word,
    output logic        io_strobe,
    output logic [15:0] io_din,
    output logic        active,
    output logic        finished
);

    localparam int CNT_MAX = (STB_HIGH > STB_LOW) ? STB_HIGH : STB_LOW;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HI_LOAD = CNT_W'(STB_HIGH - 1);
    localparam logic [CNT_W-1:0] LO_LOAD = CNT_W'(STB_LOW - 1);

    logic [CNT_W-1:0] cnt;

    // io_strobe doubles as the phase flag: high phase while it is set
    assign finished = active && !io_strobe && (cnt == '0);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            active    <= 1'b0;
            io_strobe <= 1'b0;
            io_din    <= 16'h0000;
            cnt       <= '0;
        end else if (start) begin
            active    <= 1'b1;
            io_strobe <= 1'b1;
            io_din    <= word;
            cnt       <= HI_LOAD;
        end else if (active) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (io_strobe) begin
                io_strobe <= 1'b0;
                cnt       <= LO_LOAD;
            end else begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/osd_cmd_tx.sv
// osd_cmd_tx: MPU-side transmitter for the OSD command bus.
// Accepts one request (DISABLE / ENABLE / WRITE) and frames it as
// io_osd high, command word, parameter or data words, io_osd low for OSD_GAP.
//   clk_sys, reset             - system clock, synchronous active-high reset
//   req_valid/req_ready        - request handshake, req_ready = ~busy
//   req_op/info/nostat/block/len - request fields, latched on acceptance
//   prm_*                      - info-window parameters (used with OSD_TX_PARAM_EN)
//   wr_data/wr_valid/wr_ready  - write byte stream; wr_ready pulses with the strobe
//                                rise that carries the byte
//   io_osd/io_strobe/io_din    - OSD command bus
//   busy                       - acceptance until end of gap
//   done                       - first cycle io_osd is low again
// Optional feature macro: OSD_TX_PARAM_EN. When undefined the prm_* inputs are
// ignored and ENABLE sends only its command word.
module osd_cmd_tx
    import osd_cmd_pkg::*;
#(
    parameter int STB_HIGH = 1,
    parameter int STB_LOW  = 1,
    parameter int OSD_GAP  = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic        req_info,
    input  logic        req_nostat,
    input  logic [4:0]  req_block,
    input  logic [8:0]  req_len,
    input  logic [11:0] prm_infox,
    input  logic [11:0] prm_infoy,
    input  logic [5:0]  prm_infow,
    input  logic [5:0]  prm_infoh,
    input  logic [8:0]  prm_osd_color,
    input  logic [15:0] prm_whole_color,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        io_osd,
    output logic        io_strobe,
    output logic [15:0] io_din,
    output logic        busy,
    output logic        done
);

    localparam int GAP_W = (OSD_GAP > 1) ? $clog2(OSD_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(OSD_GAP - 1);

    tx_state_e        state;
    op_e              op_q;
    logic [7:0]       cmd_q;
    logic [8:0]       len_q;
    logic [8:0]       dcnt;
    logic [GAP_W-1:0] gap_cnt;

    logic             accept;
    logic             more_data;
    logic             slot_start;
    logic [15:0]      slot_word;
    logic             slot_active;
    logic             slot_fin;
    logic             take_byte;

`ifdef OSD_TX_PARAM_EN
    logic             info_q;
    logic [2:0]       pidx;
    logic [11:0]      infox_q;
    logic [11:0]      infoy_q;
    logic [5:0]       infow_q;
    logic [5:0]       infoh_q;
    logic [8:0]       osd_color_q;
    logic [15:0]      whole_color_q;
    logic             has_param;

    assign has_param = (op_q == OP_ENABLE) && info_q;

    function automatic logic [15:0] param_word(input logic [2:0] idx);
        logic [15:0] w;
        case (idx)
            3'd0:    w = {4'h0, infox_q};
            3'd1:    w = {4'h0, infoy_q};
            3'd2:    w = {10'h000, infow_q};
            3'd3:    w = {10'h000, infoh_q};
            3'd4:    w = {7'h00, osd_color_q};
            default: w = whole_color_q;
        endcase
        return w;
    endfunction
`else
    logic unused_prm;
    assign unused_prm = ^{prm_infox, prm_infoy, prm_infow, prm_infoh,
                          prm_osd_color, prm_whole_color};
`endif

    assign req_ready = ~busy;
    assign accept    = req_valid && (state == ST_IDLE);
    assign more_data = (op_q == OP_WRITE) && (dcnt != len_q);

    // Request capture: data only, no reset needed
    always_ff @(posedge clk_sys) begin
        if (accept) begin
            op_q  <= decode_op(req_op);
            cmd_q <= encode_cmd(decode_op(req_op), req_info, req_nostat, req_block);
            len_q <= clamp_len(req_len);
`ifdef OSD_TX_PARAM_EN
            info_q        <= req_info;
            infox_q       <= prm_infox;
            infoy_q       <= prm_infoy;
            infow_q       <= prm_infow;
            infoh_q       <= prm_infoh;
            osd_color_q   <= prm_osd_color;
            whole_color_q <= prm_whole_color;
`endif
        end
    end

    // Next-word selection: a word starts either when the command slot first
    // opens or on the finishing cycle of the previous word, so slots abut.
    always_comb begin
        slot_start = 1'b0;
        slot_word  = 16'h0000;
        take_byte  = 1'b0;
        case (state)
            ST_CMD: begin
                if (!slot_active) begin
                    slot_start = 1'b1;
                    slot_word  = {8'h00, cmd_q};
`ifdef OSD_TX_PARAM_EN
                end else if (slot_fin && has_param) begin
                    slot_start = 1'b1;
                    slot_word  = param_word(3'd0);
`endif
                end else if (slot_fin && more_data && wr_valid) begin
                    slot_start = 1'b1;
                    slot_word  = {8'h00, wr_data};
                    take_byte  = 1'b1;
                end
            end
`ifdef OSD_TX_PARAM_EN
            ST_PARAM: begin
                if (slot_fin && (pidx != 3'(PARAM_WORDS))) begin
                    slot_start = 1'b1;
                    slot_word  = param_word(pidx);
                end
            end
`endif
            ST_DATA: begin
                if (slot_fin && more_data && wr_valid) begin
                    slot_start = 1'b1;
                    slot_word  = {8'h00, wr_data};
                    take_byte  = 1'b1;
                end
            end
            ST_DATA_WAIT: begin
                if (wr_valid) begin
                    slot_start = 1'b1;
                    slot_word  = {8'h00, wr_data};
                    take_byte  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Frame sequencer
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            io_osd   <= 1'b0;
            done     <= 1'b0;
            wr_ready <= 1'b0;
            dcnt     <= 9'd0;
            gap_cnt  <= '0;
`ifdef OSD_TX_PARAM_EN
            pidx     <= 3'd0;
`endif
        end else begin
            done     <= 1'b0;
            wr_ready <= take_byte;
            if (take_byte) begin
                dcnt <= dcnt + 9'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        busy  <= 1'b1;
                        dcnt  <= 9'd0;
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    io_osd <= 1'b1;
                    state  <= ST_CMD;
                end
                ST_CMD: begin
                    if (slot_fin) begin
`ifdef OSD_TX_PARAM_EN
                        if (has_param) begin
                            pidx  <= 3'd1;
                            state <= ST_PARAM;
                        end else
`endif
                        if (more_data) begin
                            state <= take_byte ? ST_DATA : ST_DATA_WAIT;
                        end else begin
                            io_osd  <= 1'b0;
                            done    <= 1'b1;
                            gap_cnt <= GAP_LOAD;
                            state   <= ST_GAP;
                        end
                    end
                end
`ifdef OSD_TX_PARAM_EN
                ST_PARAM: begin
                    if (slot_fin) begin
                        if (pidx == 3'(PARAM_WORDS)) begin
                            io_osd  <= 1'b0;
                            done    <= 1'b1;
                            gap_cnt <= GAP_LOAD;
                            state   <= ST_GAP;
                        end else begin
                            pidx <= pidx + 3'd1;
                        end
                    end
                end
`endif
                ST_DATA: begin
                    if (slot_fin) begin
                        if (!more_data) begin
                            io_osd  <= 1'b0;
                            done    <= 1'b1;
                            gap_cnt <= GAP_LOAD;
                            state   <= ST_GAP;
                        end else if (!take_byte) begin
                            state <= ST_DATA_WAIT;
                        end
                    end
                end
                ST_DATA_WAIT: begin
                    if (take_byte) begin
                        state <= ST_DATA;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    osd_strobe_slot #(
        .STB_HIGH (STB_HIGH),
        .STB_LOW  (STB_LOW)
    ) u_slot (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .start     (slot_start),
        .word      (slot_word),
        .io_strobe (io_strobe),
        .io_din    (io_din),
        .active    (slot_active),
        .finished  (slot_fin)
    );

endmodule

// File: tb/tb_osd_cmd_tx.sv
// tb_osd_cmd_tx: scoreboard bench for osd_cmd_tx (STB_HIGH=STB_LOW=1, OSD_GAP=2).
// Stimulus pushes expected strobe words, io_osd rise cycles and done cycles;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_osd_cmd_tx;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_info;
    logic        req_nostat;
    logic [4:0]  req_block;
    logic [8:0]  req_len;
    logic [11:0] prm_infox;
    logic [11:0] prm_infoy;
    logic [5:0]  prm_infow;
    logic [5:0]  prm_infoh;
    logic [8:0]  prm_osd_color;
    logic [15:0] prm_whole_color;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        io_osd;
    logic        io_strobe;
    logic [15:0] io_din;
    logic        busy;
    logic        done;

    always #5 clk_sys = ~clk_sys;

    osd_cmd_tx dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_info        (req_info),
        .req_nostat      (req_nostat),
        .req_block       (req_block),
        .req_len         (req_len),
        .prm_infox       (prm_infox),
        .prm_infoy       (prm_infoy),
        .prm_infow       (prm_infow),
        .prm_infoh       (prm_infoh),
        .prm_osd_color   (prm_osd_color),
        .prm_whole_color (prm_whole_color),
        .wr_data         (wr_data),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .io_osd          (io_osd),
        .io_strobe       (io_strobe),
        .io_din          (io_din),
        .busy            (busy),
        .done            (done)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          wr_pulses = 0;
    logic [15:0] exp_word_q[$];
    int          exp_done_q[$];
    int          exp_osd_q[$];
    logic [7:0]  src_q[$];

    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor
    logic        prev_osd = 1'b0;
    logic        prev_stb = 1'b0;
    logic [15:0] prev_din = 16'h0000;

    always @(negedge clk_sys) begin
        if (io_osd && !prev_osd) begin
            chk("osd_rise_expected", exp_osd_q.size() > 0, 1);
            if (exp_osd_q.size() > 0) chk("osd_rise_cycle", cyc, exp_osd_q.pop_front());
        end
        if (io_strobe && !prev_stb) begin
            chk("strobe_expected", exp_word_q.size() > 0, 1);
            if (exp_word_q.size() > 0) chk("strobe_word", io_din, exp_word_q.pop_front());
            chk("strobe_inside_frame", io_osd, 1);
        end
        if (prev_stb && !io_strobe && io_osd) chk("din_hold", io_din, prev_din);
        if (done) begin
            chk("done_expected", exp_done_q.size() > 0, 1);
            if (exp_done_q.size() > 0) chk("done_cycle", cyc, exp_done_q.pop_front());
            chk("done_osd_low", io_osd, 0);
        end
        if (wr_ready) begin
            wr_pulses++;
            chk("wr_ready_on_rise", io_strobe && !prev_stb, 1);
        end
        prev_osd = io_osd;
        prev_stb = io_strobe;
        prev_din = io_din;
    end

    task automatic send_req(input logic [1:0] op, input logic info, input logic nostat,
                            input logic [4:0] blk, input logic [8:0] len,
                            input int n_words, input bit push_done);
        int waited;
        @(negedge clk_sys);
        req_op = op; req_info = info; req_nostat = nostat;
        req_block = blk; req_len = len; req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 100) begin
            @(negedge clk_sys);
            waited++;
        end
        chk("req_accepted", req_ready, 1);
        // accepted on the coming edge, cycle cyc+1
        exp_osd_q.push_back(cyc + 2);
        if (push_done) exp_done_q.push_back(cyc + 1 + 2 + 2 * (1 + n_words));
        @(posedge clk_sys);
        #1 req_valid = 1'b0;
    endtask

    task automatic feed_all();
        int waited;
        while (src_q.size() > 0) begin
            wr_data  = src_q.pop_front();
            wr_valid = 1'b1;
            waited   = 0;
            do begin
                @(negedge clk_sys);
                waited++;
            end while (!wr_ready && waited < 2000);
            chk("wr_byte_taken", wr_ready, 1);
            if (!wr_ready) src_q.delete();
        end
        wr_valid = 1'b0;
    endtask

    task automatic stall_feed();
        int waited;
        wr_data  = 8'hAA;
        wr_valid = 1'b1;
        waited   = 0;
        do begin
            @(negedge clk_sys);
            waited++;
        end while (!wr_ready && waited < 2000);
        chk("stall_first_byte", wr_ready, 1);
        wr_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            chk("stall_osd_high", io_osd, 1);
            chk("stall_strobe_low", io_strobe, 0);
        end
        wr_data  = 8'hBB;
        wr_valid = 1'b1;
        exp_done_q.push_back(cyc + 3);
        @(negedge clk_sys);
        chk("stall_resume_strobe", io_strobe, 1);
        chk("stall_resume_ready", wr_ready, 1);
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        do begin
            @(negedge clk_sys);
            waited++;
        end while (busy && waited < 2000);
        chk("idle_reached", busy, 0);
        chk("words_left", exp_word_q.size(), 0);
        chk("done_left", exp_done_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_info = 1'b0;
        req_nostat = 1'b0; req_block = 5'd0; req_len = 9'd0;
        prm_infox = 12'h010; prm_infoy = 12'h020; prm_infow = 6'd8; prm_infoh = 6'd4;
        prm_osd_color = 9'h1FF; prm_whole_color = 16'h7FFF;
        wr_data = 8'h00; wr_valid = 1'b0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_io_osd", io_osd, 0);
        chk("rst_io_strobe", io_strobe, 0);
        chk("rst_io_din", io_din, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk_sys);
        chk("rst_req_ready", req_ready, 1);

        // DISABLE
        exp_word_q.push_back(16'h0040);
        send_req(2'd0, 1'b0, 1'b0, 5'd0, 9'd0, 0, 1'b1);
        wait_idle();

        // ENABLE with info window
`ifdef OSD_TX_PARAM_EN
        exp_word_q.push_back(16'h0045); exp_word_q.push_back(16'h0010);
        exp_word_q.push_back(16'h0020); exp_word_q.push_back(16'h0008);
        exp_word_q.push_back(16'h0004); exp_word_q.push_back(16'h01FF);
        exp_word_q.push_back(16'h7FFF);
        send_req(2'd1, 1'b1, 1'b0, 5'd0, 9'd0, 6, 1'b1);
`else
        exp_word_q.push_back(16'h0045);
        send_req(2'd1, 1'b1, 1'b0, 5'd0, 9'd0, 0, 1'b1);
`endif
        wait_idle();

        // ENABLE without info, nostat set
        exp_word_q.push_back(16'h0049);
        send_req(2'd1, 1'b0, 1'b1, 5'd0, 9'd0, 0, 1'b1);
        wait_idle();

        // reserved opcode behaves as DISABLE
        exp_word_q.push_back(16'h0040);
        send_req(2'd3, 1'b1, 1'b1, 5'd7, 9'd5, 0, 1'b1);
        wait_idle();

        // WRITE block 5, three bytes always available
        exp_word_q.push_back(16'h0025); exp_word_q.push_back(16'h00AA);
        exp_word_q.push_back(16'h00BB); exp_word_q.push_back(16'h00CC);
        src_q.push_back(8'hAA); src_q.push_back(8'hBB); src_q.push_back(8'hCC);
        fork
            send_req(2'd2, 1'b0, 1'b0, 5'd5, 9'd3, 3, 1'b1);
            feed_all();
        join
        wait_idle();

        // WRITE with zero length
        exp_word_q.push_back(16'h003F);
        send_req(2'd2, 1'b0, 1'b0, 5'd31, 9'd0, 0, 1'b1);
        wait_idle();

        // WRITE len 2 with a 10-cycle stall before byte 2
        exp_word_q.push_back(16'h0021); exp_word_q.push_back(16'h00AA);
        exp_word_q.push_back(16'h00BB);
        fork
            send_req(2'd2, 1'b0, 1'b0, 5'd1, 9'd2, 2, 1'b0);
            stall_feed();
        join
        wait_idle();

        // WRITE len 300 clamps to 256 bytes
        exp_word_q.push_back(16'h0020);
        for (int i = 0; i < 256; i++) begin
            exp_word_q.push_back({8'h00, 8'(i)});
            src_q.push_back(8'(i));
        end
        fork
            send_req(2'd2, 1'b0, 1'b0, 5'd0, 9'd300, 256, 1'b1);
            feed_all();
        join
        wait_idle();

        // reset during the 3rd data word
        exp_word_q.push_back(16'h0022); exp_word_q.push_back(16'h0011);
        exp_word_q.push_back(16'h0022); exp_word_q.push_back(16'h0033);
        src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
        fork
            send_req(2'd2, 1'b0, 1'b0, 5'd2, 9'd4, 4, 1'b0);
            feed_all();
        join
        chk("mid_frame_strobe", io_strobe, 1);
        reset = 1'b1;
        @(negedge clk_sys);
        chk("midrst_io_osd", io_osd, 0);
        chk("midrst_io_strobe", io_strobe, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_words_left", exp_word_q.size(), 0);
        reset = 1'b0;
        @(negedge clk_sys);
        chk("midrst_req_ready", req_ready, 1);
        exp_word_q.push_back(16'h0040);
        send_req(2'd0, 1'b0, 1'b0, 5'd0, 9'd0, 0, 1'b1);
        wait_idle();

        repeat (4) @(negedge clk_sys);
        chk("wr_ready_pulse_count", wr_pulses, 3 + 2 + 256 + 3);
        chk("osd_rise_left", exp_osd_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
